hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MD_LATENCY, default 32, giving the multiply/divide unit busy cycles, legal range 2..64.
REQ-002 SHALL have port clk  in  1  rising-edge system clock.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports rsD, rtD  in  5 each  source registers of the ID-stage instruction.
REQ-005 SHALL have ports rsE, rtE  in  5 each  source registers of the EX-stage instruction.
REQ-006 SHALL have ports writeRegE, writeRegM, writeRegW  in  5 each  destination registers of EX, MEM and WB.
REQ-007 SHALL have ports regWriteE, regWriteM, regWriteW, memToRegE, memToRegM  in  1 each  stage write and load flags.
REQ-008 SHALL have ports branchD, branchTakenD, jumpD, jrD  in  1 each  ID-stage control-flow flags.
REQ-009 SHALL have ports mdStartE, mdUseD  in  1 each  mult/div issued in EX; ID instruction needs HI/LO or the mult/div unit.
REQ-010 SHALL have ports stallF, stallD, flushD, flushE  out  1 each  pipeline-register control.
REQ-011 SHALL have ports forwardAD, forwardBD  out  1 each  and forwardAE, forwardBE  out  2 each  forwarding selects.
REQ-012 SHALL have port mdBusy  out  1  asserted while the mult/div unit is running.

Function
REQ-013 SHALL treat register 0 as never matching in any hazard or forward comparison.
REQ-014 SHALL set lwStall when memToRegE and regWriteE are high and writeRegE equals rsD or rtD.
REQ-015 SHALL set brStall when (branchD or jrD) and either regWriteE with writeRegE matching rsD or rtD, or memToRegM with writeRegM matching.
REQ-016 SHALL set mdStall when mdUseD and mdBusy are both high.
REQ-017 SHALL drive stallF = stallD = flushE = lwStall or brStall or mdStall or rawStall (REQ-026), combinationally in the same cycle.
REQ-018 SHALL drive flushD = (jumpD or jrD or branchTakenD) and not stallD; a stall suppresses the flush in that cycle.
REQ-019 SHALL drive forwardAE = 2'b10 when regWriteM and writeRegM == rsE, else 2'b01 when regWriteW and writeRegW == rsE, else 2'b00; forwardBE the same using rtE; MEM takes priority over WB.
REQ-020 SHALL drive forwardAD = regWriteM and writeRegM == rsD, and forwardBD the same using rtD.
REQ-021 SHALL implement a two-state FSM: IDLE and BUSY, with a 6-bit down-counter.
REQ-022 In IDLE, mdStartE SHALL load the counter with MD_LATENCY-1 and move to BUSY on the next edge.
REQ-023 In BUSY, the counter SHALL decrement each cycle; at count 0 the FSM SHALL return to IDLE; mdBusy = (state == BUSY).
REQ-024 mdStartE asserted in BUSY SHALL reload MD_LATENCY-1 and remain in BUSY.
REQ-025 mdStartE coincident with the final BUSY cycle (count 0) SHALL reload and remain in BUSY.

Configuration
REQ-026 With FORWARD_EN defined, forwarding SHALL operate per REQ-019/020 and rawStall SHALL be 0.
REQ-027 Without FORWARD_EN, all forward selects SHALL be 0, and rawStall SHALL be set when regWriteE or regWriteM has a destination matching rsD or rtD; WB needs no stall because the register file writes in the first half-cycle.

Reset
REQ-028 While reset is low, FSM SHALL be IDLE, counter 0, mdBusy 0, and all stall, flush and forward outputs SHALL be 0, asynchronously.
REQ-029 Reset asserted while BUSY SHALL abort the operation; after release the FSM SHALL start in IDLE with no residual stall.

Verification
REQ-030 lw $8 in EX (memToRegE=1, writeRegE=8), rsD=8 -> stallF=stallD=flushE=1, flushD=0 for one cycle.
REQ-031 beq in ID with rsD=9, regWriteE=1, writeRegE=9, branchTakenD=1 -> stall=1, flushD=0; next cycle, hazard cleared -> flushD=1.
REQ-032 FORWARD_EN defined, writeRegM=writeRegW=5, both regWrite=1, rsE=5 -> forwardAE=2'b10; drop regWriteM -> 2'b01; rsE=0 -> 2'b00.
REQ-033 MD_LATENCY=4, mdStartE pulse, then mdUseD=1 -> mdBusy high exactly 4 cycles, stallD high for those cycles, then both 0.
REQ-034 reset pulled low during BUSY count 2 -> mdBusy and all stalls 0 immediately; after release, mdUseD=1 -> no stall.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard unit for a 5-stage MIPS-style core.
// Generates stall/flush controls, EX and ID forwarding selects, and tracks
// the multi-cycle mult/div unit with a small IDLE/BUSY down-counter FSM.
// Optional feature macro: FORWARD_EN (bypass network present). When it is
// undefined, all forward selects are tied to 0 and RAW hazards on EX/MEM
// destinations stall instead.
module hazard_ctrl #(
  parameter int MD_LATENCY = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic [4:0] rsE,
  input  logic [4:0] rtE,
  input  logic [4:0] writeRegE,
  input  logic [4:0] writeRegM,
  input  logic [4:0] writeRegW,
  input  logic       regWriteE,
  input  logic       regWriteM,
  input  logic       regWriteW,
  input  logic       memToRegE,
  input  logic       memToRegM,
  input  logic       branchD,
  input  logic       branchTakenD,
  input  logic       jumpD,
  input  logic       jrD,
  input  logic       mdStartE,
  input  logic       mdUseD,
  output logic       stallF,
  output logic       stallD,
  output logic       flushD,
  output logic       flushE,
  output logic       forwardAD,
  output logic       forwardBD,
  output logic [1:0] forwardAE,
  output logic [1:0] forwardBE,
  output logic       mdBusy
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} md_state_e;

  localparam logic [5:0] MD_LOAD = 6'(MD_LATENCY - 1);

  md_state_e  state_q;
  logic [5:0] cnt_q;

  logic lwStall, brStall, mdStall, rawStall, stall;
  logic dHitE, dHitM;

  // $0 is hardwired zero, so it never creates a dependency
  function automatic logic hit(input logic [4:0] dst, input logic [4:0] src);
    return (dst != 5'd0) && (dst == src);
  endfunction

  // ID-stage sources against EX/MEM destinations
  always_comb begin
    dHitE   = hit(writeRegE, rsD) || hit(writeRegE, rtD);
    dHitM   = hit(writeRegM, rsD) || hit(writeRegM, rtD);
    lwStall = memToRegE && regWriteE && dHitE;
    // branch compare happens in ID, so an EX result or a MEM load is too late
    brStall = (branchD || jrD) && ((regWriteE && dHitE) || (memToRegM && dHitM));
    mdStall = mdUseD && mdBusy;
`ifdef FORWARD_EN
    rawStall = 1'b0;
`else
    // no bypass: wait until the producer reaches WB (regfile writes first half)
    rawStall = (regWriteE && dHitE) || (regWriteM && dHitM);
`endif
  end

  // stall/flush outputs; forced low while reset is held
  always_comb begin
    stall  = reset && (lwStall || brStall || mdStall || rawStall);
    stallF = stall;
    stallD = stall;
    flushE = stall;
    // a stalled ID instruction must not be squashed by its own redirect
    flushD = reset && (jumpD || jrD || branchTakenD) && !stall;
  end

  // forwarding selects: MEM result beats WB result
  always_comb begin
    forwardAE = 2'b00;
    forwardBE = 2'b00;
    forwardAD = 1'b0;
    forwardBD = 1'b0;
`ifdef FORWARD_EN
    if (reset) begin
      if (regWriteM && hit(writeRegM, rsE))      forwardAE = 2'b10;
      else if (regWriteW && hit(writeRegW, rsE)) forwardAE = 2'b01;
      if (regWriteM && hit(writeRegM, rtE))      forwardBE = 2'b10;
      else if (regWriteW && hit(writeRegW, rtE)) forwardBE = 2'b01;
      forwardAD = regWriteM && hit(writeRegM, rsD);
      forwardBD = regWriteM && hit(writeRegM, rtD);
    end
`endif
  end

  // mult/div occupancy FSM; a new start always restarts the full latency
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
    end else begin
      case (state_q)
        IDLE: if (mdStartE) begin
          cnt_q   <= MD_LOAD;
          state_q <= BUSY;
        end
        BUSY: begin
          if (mdStartE)            cnt_q   <= MD_LOAD;
          else if (cnt_q == 6'd0)  state_q <= IDLE;
          else                     cnt_q   <= cnt_q - 6'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mdBusy = (state_q == BUSY);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (MD_LATENCY=4). Covers both FORWARD_EN builds.
module tb_hazard_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW;
  logic       regWriteE, regWriteM, regWriteW, memToRegE, memToRegM;
  logic       branchD, branchTakenD, jumpD, jrD, mdStartE, mdUseD;
  logic       stallF, stallD, flushD, flushE, forwardAD, forwardBD, mdBusy;
  logic [1:0] forwardAE, forwardBE;

  int checks = 0;
  int failures = 0;

  hazard_ctrl #(.MD_LATENCY(4)) dut (
    .clk(clk), .reset(reset),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeRegE(writeRegE), .writeRegM(writeRegM), .writeRegW(writeRegW),
    .regWriteE(regWriteE), .regWriteM(regWriteM), .regWriteW(regWriteW),
    .memToRegE(memToRegE), .memToRegM(memToRegM),
    .branchD(branchD), .branchTakenD(branchTakenD), .jumpD(jumpD), .jrD(jrD),
    .mdStartE(mdStartE), .mdUseD(mdUseD),
    .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
    .forwardAD(forwardAD), .forwardBD(forwardBD),
    .forwardAE(forwardAE), .forwardBE(forwardBE), .mdBusy(mdBusy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // packed view: {stallF,stallD,flushE,flushD}
  function automatic logic [3:0] sf();
    return {stallF, stallD, flushE, flushD};
  endfunction

  task automatic clr();
    {rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW} = '0;
    {regWriteE, regWriteM, regWriteW, memToRegE, memToRegM} = '0;
    {branchD, branchTakenD, jumpD, jrD, mdStartE, mdUseD} = '0;
  endtask

  initial begin
    clr();
    reset = 1'b0;
    // hazard present while in reset: everything must stay low
    memToRegE = 1; regWriteE = 1; writeRegE = 5'd8; rsD = 5'd8; jumpD = 1;
    regWriteM = 1; writeRegM = 5'd3; rsE = 5'd3;
    #3;
    chk("rst_sf", 32'(sf()), 32'h0);
    chk("rst_busy", 32'(mdBusy), 32'h0);
    chk("rst_fwd", 32'({forwardAE, forwardBE, forwardAD, forwardBD}), 32'h0);
    clr();
    @(negedge clk); reset = 1'b1;
    @(negedge clk);

    // load-use
    memToRegE = 1; regWriteE = 1; writeRegE = 5'd8; rsD = 5'd8; #1;
    chk("lw_rs", 32'(sf()), 32'hE);
    rsD = 5'd0; rtD = 5'd8; #1;
    chk("lw_rt", 32'(sf()), 32'hE);
    // $0 never matches
    writeRegE = 5'd0; rtD = 5'd0; #1;
    chk("lw_r0", 32'(sf()), 32'h0);
    clr(); #1;
    chk("idle_sf", 32'(sf()), 32'h0);

    // taken branch waiting on EX result, then resolved
    branchD = 1; branchTakenD = 1; rsD = 5'd9; regWriteE = 1; writeRegE = 5'd9; #1;
    chk("beq_stall", 32'(sf()), 32'hE);
    regWriteE = 0; #1;
    chk("beq_flush", 32'(sf()), 32'h1);
    clr();
    // branch waiting on a load in MEM
    branchD = 1; memToRegM = 1; writeRegM = 5'd7; rtD = 5'd7; #1;
    chk("br_ldM", 32'(sf()), 32'hE);
    clr();
    // jr on EX result
    jrD = 1; rsD = 5'd4; regWriteE = 1; writeRegE = 5'd4; #1;
    chk("jr_stall", 32'(sf()), 32'hE);
    clr();
    jumpD = 1; #1;
    chk("j_flush", 32'(sf()), 32'h1);
    clr();

    // forwarding / RAW behaviour
    regWriteM = 1; regWriteW = 1; writeRegM = 5'd5; writeRegW = 5'd5; rsE = 5'd5; rtE = 5'd5; #1;
`ifdef FORWARD_EN
    chk("fwdAE_M", 32'(forwardAE), 32'h2);
    chk("fwdBE_M", 32'(forwardBE), 32'h2);
    regWriteM = 0; #1;
    chk("fwdAE_W", 32'(forwardAE), 32'h1);
    rsE = 5'd0; #1;
    chk("fwdAE_0", 32'(forwardAE), 32'h0);
    chk("fwdBE_W", 32'(forwardBE), 32'h1);
    clr();
    regWriteM = 1; writeRegM = 5'd6; rsD = 5'd6; #1;
    chk("fwdAD", 32'({forwardAD, forwardBD}), 32'h2);
    chk("fwd_nostall", 32'(sf()), 32'h0);
    rsD = 5'd0; rtD = 5'd6; #1;
    chk("fwdBD", 32'({forwardAD, forwardBD}), 32'h1);
`else
    chk("nofwd_E", 32'({forwardAE, forwardBE}), 32'h0);
    regWriteM = 0; #1;
    chk("nofwd_W", 32'({forwardAE, forwardBE}), 32'h0);
    clr();
    regWriteM = 1; writeRegM = 5'd6; rsD = 5'd6; #1;
    chk("raw_M", 32'(sf()), 32'hE);
    chk("nofwd_D", 32'({forwardAD, forwardBD}), 32'h0);
    clr();
    regWriteE = 1; writeRegE = 5'd2; rtD = 5'd2; #1;
    chk("raw_E", 32'(sf()), 32'hE);
    clr();
    regWriteW = 1; writeRegW = 5'd6; rsD = 5'd6; #1;
    chk("raw_W_none", 32'(sf()), 32'h0);
`endif
    clr();

    // mult/div: 4 busy cycles, ID user stalls throughout
    @(negedge clk);
    mdStartE = 1; mdUseD = 1; #1;
    chk("md_pre", 32'({mdBusy, stallD}), 32'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); mdStartE = 0; #1;
      chk($sformatf("md_c%0d", i), 32'({mdBusy, stallD}), (i < 4) ? 32'h3 : 32'h0);
    end

    // restart coincident with count 0 keeps it busy another 4 cycles
    mdUseD = 0; mdStartE = 1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk); mdStartE = (i == 3); #1;
      chk($sformatf("md_re%0d", i), 32'(mdBusy), (i < 8) ? 32'h1 : 32'h0);
    end
    mdStartE = 0;

    // async reset while BUSY at count 2
    @(negedge clk); mdStartE = 1;
    @(negedge clk); mdStartE = 0;   // count 3
    @(negedge clk); mdUseD = 1; #1; // count 2
    chk("md_busy2", 32'({mdBusy, stallD}), 32'h3);
    reset = 1'b0; #1;
    chk("md_abort", 32'({mdBusy, stallF, stallD, flushE}), 32'h0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); #1;
    chk("md_post", 32'({mdBusy, stallF, stallD, flushE}), 32'h0);
    @(negedge clk); #1;
    chk("md_post2", 32'({mdBusy, stallD}), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
